// File: rtl/dma_div_pkg.sv
// dma_div_pkg -- shared types and helpers for the fixed-point divider.
//   div_state_e : controller states (IDLE, ABS, RUN, DONE)
//   cnt_width   : iteration counter width for a WIDTH/FRAC pair
//   sat_max_pos : bit pattern of the largest positive value at a width
//   sat_min_neg : bit pattern of the most negative value at a width
//                 (also the magnitude 2^(width-1) read as unsigned)
// The saturation helpers return 64 bits; callers cast to the width they need.
package dma_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ABS  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

   function automatic int cnt_width(input int width, input int frac);
      return $clog2(width + frac);
   endfunction

   function automatic logic [63:0] sat_max_pos(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min_neg(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/dma_div_step.sv
// dma_div_step -- one combinational restoring-division step.
//   acc     in  N  partial remainder
//   dvd_msb in  1  dividend bit shifted into the remainder this step
//   divisor in  N  divisor magnitude (zero-extended)
//   q       in  N  quotient so far
//   acc_nx  out N  remainder after the trial subtraction
//   q_nx    out N  quotient with the new bit shifted in
module dma_div_step #(
   parameter int N = 48
) (
   input  logic [N-1:0] acc,
   input  logic         dvd_msb,
   input  logic [N-1:0] divisor,
   input  logic [N-1:0] q,
   output logic [N-1:0] acc_nx,
   output logic [N-1:0] q_nx
);

   logic [N:0] trial_s;
   logic [N:0] diff_s;
   logic       ge_s;

   // Trial subtraction one bit wider than N so the shifted remainder never wraps.
   always_comb begin
      trial_s = {acc, dvd_msb};
      diff_s  = trial_s - {1'b0, divisor};
      ge_s    = (trial_s >= {1'b0, divisor});
      if (ge_s) begin
         acc_nx = N'(diff_s);
      end else begin
         acc_nx = N'(trial_s);
      end
      q_nx = N'({q, ge_s});
   end

endmodule

// File: rtl/dma_fxp_divider.sv
// dma_fxp_divider -- iterative signed fixed-point divider,
// out = (in1 << FRAC) / in2, truncated toward zero, one division at a time.
//   clk, rst  : clock, synchronous active-high reset
//   in1, in2  : signed dividend / divisor, captured when start is accepted
//   start     : request, accepted only while busy is low
//   busy      : operation in flight
//   out       : registered signed quotient, held until the next rdy
//   rdy       : one-cycle result-valid pulse
//   div_zero  : with rdy, divisor was zero
//   ovf       : with rdy, quotient did not fit in WIDTH bits
// Latency is WIDTH+FRAC+2 edges from acceptance to rdy, 2 for a zero divisor.
module dma_fxp_divider
   import dma_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] out,
   output logic             rdy,
   output logic             div_zero,
   output logic             ovf
);

   localparam int N  = WIDTH + FRAC;
   localparam int CW = cnt_width(WIDTH, FRAC);

   localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [N-1:0]     ZERO_N   = {N{1'b0}};
   localparam logic [CW-1:0]    ZERO_C   = {CW{1'b0}};
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(sat_max_pos(WIDTH));
   localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(sat_min_neg(WIDTH));
   // Largest quotient magnitudes that still fit, for a positive / negative result.
   localparam logic [N-1:0]     LIM_POS  = N'(sat_max_pos(WIDTH));
   localparam logic [N-1:0]     LIM_NEG  = N'(sat_min_neg(WIDTH));

   div_state_e state_r;
   div_state_e state_nx_s;

   logic [WIDTH-1:0] in1_r;
   logic [WIDTH-1:0] in2_r;
   logic [WIDTH-1:0] mag2_r;
   logic             neg_r;
   logic [N-1:0]     dvd_r;
   logic [N-1:0]     acc_r;
   logic [N-1:0]     q_r;
   logic [CW-1:0]    cnt_r;

   logic [WIDTH-1:0] out_r;
   logic             rdy_r;
   logic             busy_r;
   logic             dz_r;
   logic             ovf_r;

   logic [WIDTH-1:0] mag1_s;
   logic [WIDTH-1:0] mag2_s;
   logic [N-1:0]     acc_nx_s;
   logic [N-1:0]     q_nx_s;
   logic [N-1:0]     res_s;
   logic             over_s;
   logic [WIDTH-1:0] out_nx_s;
   logic             dz_nx_s;
   logic             ovf_nx_s;

   dma_div_step #(.N(N)) u_step (
      .acc     (acc_r),
      .dvd_msb (dvd_r[N-1]),
      .divisor (N'(mag2_r)),
      .q       (q_r),
      .acc_nx  (acc_nx_s),
      .q_nx    (q_nx_s)
   );

   // Operand magnitudes; negating the most negative value wraps to 2^(WIDTH-1),
   // which is exactly right when read as unsigned.
   always_comb begin
      if (in1_r[WIDTH-1]) begin
         mag1_s = -in1_r;
      end else begin
         mag1_s = in1_r;
      end
      if (in2_r[WIDTH-1]) begin
         mag2_s = -in2_r;
      end else begin
         mag2_s = in2_r;
      end
   end

   // Final result selection: divide-by-zero clamp, overflow handling, sign restore.
   always_comb begin
      if (neg_r) begin
         res_s  = -q_r;
         over_s = (q_r > LIM_NEG);
      end else begin
         res_s  = q_r;
         over_s = (q_r > LIM_POS);
      end
      out_nx_s = WIDTH'(res_s);
      dz_nx_s  = 1'b0;
      ovf_nx_s = 1'b0;
      if (in2_r == ZERO_W) begin
         dz_nx_s = 1'b1;
         if (in1_r[WIDTH-1]) begin
            out_nx_s = MIN_W;
         end else begin
            out_nx_s = MAX_W;
         end
      end else if (over_s) begin
         ovf_nx_s = 1'b1;
         if (SAT != 0) begin
            if (neg_r) begin
               out_nx_s = MIN_W;
            end else begin
               out_nx_s = MAX_W;
            end
         end else begin
            out_nx_s = WIDTH'(res_s);
         end
      end else begin
         out_nx_s = WIDTH'(res_s);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_ABS;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ABS: begin
            if (in2_r == ZERO_W) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Datapath and output registers; rdy and the flags default low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         in1_r  <= ZERO_W;
         in2_r  <= ZERO_W;
         mag2_r <= ZERO_W;
         neg_r  <= 1'b0;
         dvd_r  <= ZERO_N;
         acc_r  <= ZERO_N;
         q_r    <= ZERO_N;
         cnt_r  <= ZERO_C;
         out_r  <= ZERO_W;
         rdy_r  <= 1'b0;
         busy_r <= 1'b0;
         dz_r   <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         rdy_r <= 1'b0;
         dz_r  <= 1'b0;
         ovf_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  in1_r  <= in1;
                  in2_r  <= in2;
                  busy_r <= 1'b1;
               end
            end
            ST_ABS: begin
               mag2_r <= mag2_s;
               neg_r  <= in1_r[WIDTH-1] ^ in2_r[WIDTH-1];
               dvd_r  <= N'(mag1_s) << FRAC;
               acc_r  <= ZERO_N;
               q_r    <= ZERO_N;
               cnt_r  <= ZERO_C;
            end
            ST_RUN: begin
               acc_r <= acc_nx_s;
               q_r   <= q_nx_s;
               dvd_r <= dvd_r << 1;
               cnt_r <= cnt_r + CW'(1);
            end
            ST_DONE: begin
               out_r  <= out_nx_s;
               dz_r   <= dz_nx_s;
               ovf_r  <= ovf_nx_s;
               rdy_r  <= 1'b1;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign out      = out_r;
   assign rdy      = rdy_r;
   assign busy     = busy_r;
   assign div_zero = dz_r;
   assign ovf      = ovf_r;

endmodule
